// File: rtl/mmn_argmax_reader.sv
// Sequential argmax over one captured class-score vector, one score per cycle.
// Returns the lowest index holding the maximum score through a valid/ready handshake.
module mmn_argmax_reader #(
  parameter int  NUM_CLASSES = 10,
  parameter int  PX_SIZE     = 8,
  parameter bit  SIGNED      = 1'b0,
  localparam int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CLASSES-1:0][PX_SIZE-1:0] scores_in,
  input  logic                                scores_valid,
  output logic                                scores_ready,
  output logic [IDX_W-1:0]                    class_out,
  output logic [PX_SIZE-1:0]                  max_score,
  output logic                                class_valid,
  input  logic                                class_ready,
  output logic                                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  function automatic logic score_gt(input logic [PX_SIZE-1:0] a, input logic [PX_SIZE-1:0] b);
    logic r;
    if (SIGNED) begin
      r = ($signed(a) > $signed(b));
    end else begin
      r = (a > b);
    end
    return r;
  endfunction

  state_t                               r_state, w_state;
  logic [NUM_CLASSES-1:0][PX_SIZE-1:0]  r_cap, w_cap;
  logic [IDX_W-1:0]                     r_cnt, w_cnt;
  logic [PX_SIZE-1:0]                   r_best, w_best;
  logic [IDX_W-1:0]                     r_best_idx, w_best_idx;
  logic                                 r_ready, w_ready;
  logic                                 r_valid, w_valid;
  logic                                 r_busy, w_busy;
  logic [IDX_W-1:0]                     r_class, w_class;
  logic [PX_SIZE-1:0]                   r_max, w_max;
  logic [PX_SIZE-1:0]                   w_sel;
  logic                                 w_gt;

  // Score currently addressed by the scan counter.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      w_sel = (r_cnt == IDX_W'(i)) ? r_cap[i] : w_sel;
    end
  end

  // Next-state and next-output logic; equal scores never replace best so ties go low.
  always_comb begin
    w_state    = r_state;
    w_cap      = r_cap;
    w_cnt      = r_cnt;
    w_best     = r_best;
    w_best_idx = r_best_idx;
    w_ready    = r_ready;
    w_valid    = r_valid;
    w_busy     = r_busy;
    w_class    = r_class;
    w_max      = r_max;
    w_gt       = score_gt(w_sel, r_best);
    case (r_state)
      S_IDLE: begin
        if (r_ready && scores_valid) begin
          w_cap      = scores_in;
          w_best     = scores_in[0];
          w_best_idx = '0;
          w_cnt      = IDX_W'(1);
          w_ready    = 1'b0;
          w_busy     = 1'b1;
          if (NUM_CLASSES == 32'sd1) begin
            w_state = S_DONE;
            w_valid = 1'b1;
            w_class = '0;
            w_max   = scores_in[0];
          end else begin
            w_state = S_SCAN;
          end
        end else begin
          w_ready = 1'b1;
        end
      end
      S_SCAN: begin
        w_best     = w_gt ? w_sel : r_best;
        w_best_idx = w_gt ? r_cnt : r_best_idx;
        w_cnt      = r_cnt + IDX_W'(1);
        if (r_cnt == LAST_IDX) begin
          w_state = S_DONE;
          w_valid = 1'b1;
          w_class = w_best_idx;
          w_max   = w_best;
        end else begin
          w_state = S_SCAN;
        end
      end
      S_DONE: begin
        if (class_ready) begin
          w_state = S_IDLE;
          w_valid = 1'b0;
          w_ready = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_state = S_DONE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
        w_ready = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap      <= '0;
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_class    <= '0;
      r_max      <= '0;
    end else begin
      r_cap      <= w_cap;
      r_cnt      <= w_cnt;
      r_best     <= w_best;
      r_best_idx <= w_best_idx;
      r_ready    <= w_ready;
      r_valid    <= w_valid;
      r_busy     <= w_busy;
      r_class    <= w_class;
      r_max      <= w_max;
    end
  end

  assign scores_ready = r_ready;
  assign class_valid  = r_valid;
  assign class_out    = r_class;
  assign max_score    = r_max;
  assign busy         = r_busy;

endmodule
